// File: rtl/pde_ctrl_pkg.sv
// Shared types for the RK2 step sequencer and the integrator cell it wraps.
// The phase encoding lives here so both blocks step through K1/K2/UPD identically.
package pde_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_K1  = 2'd0;
    localparam phase_t PH_K2  = 2'd1;
    localparam phase_t PH_UPD = 2'd2;

    localparam int unsigned CTRL_DATA_WIDTH = 16;
    localparam int unsigned CTRL_STEP_WIDTH = 16;

    // Sample record as seen by the trace/host side at the default widths.
    typedef struct packed {
        logic signed [CTRL_DATA_WIDTH-1:0] y;
        logic        [CTRL_STEP_WIDTH-1:0] step;
    } sample_t;

    function automatic phase_t next_phase(input phase_t p);
        return (p == PH_UPD) ? PH_K1 : phase_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead sample buffer: head entry is always on rdata, empty/full flags,
// and a drop strobe for a push that could not be accepted.
module sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rdata   = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = wdata;
            wr_d                = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/rk2_step_sequencer.sv
// Run controller around one RK2 DDA cell: holds it in reset while idle, tracks the
// 3-phase step cadence, counts steps, handles y0 reloads and decimated sample capture.
module rk2_step_sequencer
    import pde_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned STEP_WIDTH = 16,
    parameter int unsigned DECIM      = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         reload,
    input  logic        [STEP_WIDTH-1:0] num_steps,
    input  logic signed [DATA_WIDTH-1:0] y_in,
    output logic                         cell_rst,
    output logic                         set_y,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun,
    output logic                         s_valid,
    input  logic                         s_ready,
    output logic signed [DATA_WIDTH-1:0] s_data,
    output logic        [STEP_WIDTH-1:0] s_step
);

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] y;
        logic        [STEP_WIDTH-1:0] step;
    } smp_t;

    localparam logic [STEP_WIDTH-1:0] DEC_LAST = STEP_WIDTH'(DECIM - 1);

    state_e                state_q, state_d;
    phase_t                phase_q, phase_d;
    logic [STEP_WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [STEP_WIDTH-1:0] num_q, num_d;
    logic [STEP_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
    logic                  reload_pend_q, reload_pend_d;
    logic                  overrun_q, overrun_d;
    logic                  cell_rst_q, cell_rst_d;
    logic                  set_y_q, set_y_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic in_k1, in_upd, cap_due, last_step;
    logic push, pop, fifo_full, fifo_empty, fifo_drop;
    smp_t push_smp, head_smp;

    assign in_k1     = (state_q == ST_RUN) && (phase_q == PH_K1);
    assign in_upd    = (state_q == ST_RUN) && (phase_q == PH_UPD);
    assign cap_due   = (dec_cnt_q == '0);
    assign last_step = (step_cnt_q == num_q);
    assign push      = in_k1 && cap_due;
    assign pop       = s_valid && s_ready;
    assign push_smp  = '{y: y_in, step: step_cnt_q};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (in_k1 && last_step) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // Step, decimation and reload bookkeeping
    always_comb begin
        phase_d       = PH_K1;
        step_cnt_d    = step_cnt_q;
        num_d         = num_q;
        dec_cnt_d     = dec_cnt_q;
        reload_pend_d = reload_pend_q;
        overrun_d     = overrun_q;
        if (state_q == ST_LOAD) begin
            num_d         = num_steps;
            step_cnt_d    = '0;
            dec_cnt_d     = '0;
            reload_pend_d = 1'b0;
            overrun_d     = 1'b0;
        end else if (state_q == ST_RUN) begin
            phase_d       = next_phase(phase_q);
            reload_pend_d = (reload_pend_q || reload) && !(in_upd && set_y_q);
            if (in_upd) begin
                if (set_y_q) begin
                    step_cnt_d = '0;
                    dec_cnt_d  = '0;
                end else begin
                    if (step_cnt_q != '1) step_cnt_d = step_cnt_q + 1'b1;
                    dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + 1'b1;
                end
            end
        end
        if (fifo_drop) overrun_d = 1'b1;
    end

    // Registered control outputs, decoded from the state being entered
    always_comb begin
        cell_rst_d = (state_d != ST_RUN);
        busy_d     = (state_d == ST_LOAD) || (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
        set_y_d    = (state_q == ST_RUN) && (phase_q == PH_K2) && (reload_pend_q || reload);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= PH_K1;
            step_cnt_q    <= '0;
            num_q         <= '0;
            dec_cnt_q     <= '0;
            reload_pend_q <= 1'b0;
            overrun_q     <= 1'b0;
            cell_rst_q    <= 1'b1;
            set_y_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            step_cnt_q    <= step_cnt_d;
            num_q         <= num_d;
            dec_cnt_q     <= dec_cnt_d;
            reload_pend_q <= reload_pend_d;
            overrun_q     <= overrun_d;
            cell_rst_q    <= cell_rst_d;
            set_y_q       <= set_y_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + STEP_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_smp),
        .pop   (pop),
        .rdata (head_smp),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    drop_implies_full: assert property (@(posedge clk) disable iff (!rst_n) fifo_drop |-> fifo_full);

    assign cell_rst = cell_rst_q;
    assign set_y    = set_y_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;
    assign s_valid  = !fifo_empty;
    assign s_data   = head_smp.y;
    assign s_step   = head_smp.step;

endmodule

// File: doc/rk2_step_sequencer.md
Name: rk2_step_sequencer

Overview:
- Run controller and sample collector placed directly around one RK2 DDA integrator cell.
- Holds the cell in reset while idle. Releases it on start and tracks the cell's 3-phase cadence (phase 0, 1, 2 = one RK2 step).
- Counts completed steps, drives set_y for mid-run reloads, and captures the cell's y every DECIM steps.
- Captured samples go into a small FIFO that drains over a valid/ready stream to the trace/host side.

Parameters:
- DATA_WIDTH, 16: width of y samples (matches the cell).
- STEP_WIDTH, 16: width of the step counter and num_steps.
- DECIM, 1: capture every DECIM-th step; must be ≥1.
- FIFO_DEPTH, 4: sample buffer entries; power of two, ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when IDLE or DONE.
- reload  in  1  one-cycle pulse; reloads y0 at the next step boundary while RUN.
- num_steps  in  STEP_WIDTH  steps per run; sampled on start.
- y_in  in  DATA_WIDTH signed  cell y output.
- cell_rst  out  1  active-high reset to the cell.
- set_y  out  1  cell set_y.
- busy  out  1  high in LOAD/RUN.
- done  out  1  high in DONE.
- overrun  out  1  sticky: a due sample was dropped because the FIFO was full.
- s_valid  out  1  sample available.
- s_ready  in  1  consumer accepts.
- s_data  out  DATA_WIDTH signed  sample y.
- s_step  out  STEP_WIDTH  step index of the sample.

Behaviour:
- Reset (rst_n low, async) drives the outputs to:
  - cell_rst=1, set_y=0, busy=0, done=0, overrun=0, s_valid=0;
  - s_data=0, s_step=0; FIFO empty; state IDLE; phase=0; step_cnt=0.
- States:
  - IDLE: cell_rst=1. start → LOAD.
  - LOAD: one cycle, cell_rst=1. Latches num_steps, clears step_cnt and overrun, sets phase=0. Next state RUN.
  - RUN: cell_rst=0. phase cycles 0→1→2→0 every clk, in lockstep with the cell; the first RUN cycle is phase 0.
  - DONE: cell_rst=1, done=1. start → LOAD. The FIFO keeps draining in DONE.
- All control outputs are registered. cell_rst deasserts on the clk edge entering RUN.
- Step counting: at the end of each phase-2 cycle, step_cnt increments with no wrap. The cell's new y is valid from the following phase-0 cycle.
- Capture:
  - In each RUN phase-0 cycle where step_cnt mod DECIM == 0, push {y_in, step_cnt} into the FIFO.
  - The first capture is step 0, which holds y0.
  - DECIM=1 must not use a divider: keep a decimation counter that resets to 0 on each capture.
- Termination: in the phase-0 cycle where step_cnt == num_steps, do the capture if it is due, then go to DONE on the next edge.
  - num_steps=0 → exactly one sample (step 0), then DONE after 1 RUN cycle.
  - A final step that is not a multiple of DECIM is not captured.
- Reload:
  - reload in RUN sets a pending flag.
  - set_y=1 is driven for exactly the next phase-2 cycle, so the cell loads y0 instead of y+dy.
  - step_cnt and the decimation counter clear to 0 at that edge instead of incrementing.
  - reload outside RUN is ignored. A second reload while pending is merged.
- start while in LOAD/RUN is ignored.
- FIFO:
  - Show-ahead: s_data/s_step are the head entry. s_valid = not empty.
  - A pop occurs on s_valid & s_ready.
  - A simultaneous push and pop when full is allowed: count is unchanged.
  - Push when full without a pop → sample dropped, overrun=1, held until the next LOAD.
  - s_valid must not depend combinationally on s_ready.
- Deasserting rst_n mid-run aborts immediately: the FIFO is flushed and the cell is forced into reset.

Decomposition:
- Package pde_ctrl_pkg:
  - state enum (IDLE, LOAD, RUN, DONE);
  - 2-bit phase type with constants PH_K1=0, PH_K2=1, PH_UPD=2;
  - a sample struct {y, step}.
  - The cell's phase encoding is defined there too, so both blocks agree.
- Sub-module sample_fifo: parameterized depth/width, show-ahead, with full/empty flags and a push-when-full drop indication.

Test Plan:
- Run, cell y0=100, dy=+4 constant, num_steps=3, DECIM=1, s_ready=1 → samples (100,0), (104,1), (108,2), (112,3).
  - Cycle gaps between samples are 3 clocks; done rises 1 cycle after the last capture; cell_rst is high before and after the run.
- DECIM=2, num_steps=5 → samples at steps 0, 2, 4 only; DONE after step 5; overrun=0.
- s_ready=0 throughout, FIFO_DEPTH=4, num_steps=6 → first 4 samples retained, overrun=1.
  - Then raise s_ready → exactly steps 0–3 drain.
  - A new start clears overrun.
- reload pulsed during step 2's phase 1 → set_y high for exactly the next phase-2 cycle.
  - The next sample is (y0, 0), and the run continues until the restarted count reaches num_steps.
- num_steps=0 → one sample (y0, 0), DONE; start pulsed in RUN is ignored.
- rst_n low mid-RUN with 2 entries buffered → s_valid=0 immediately, cell_rst=1, state IDLE, no spurious samples after release.
